// File: rtl/lsp_cb_pkg.sv
// Shared constants for the scalar LSP codebook search: Q15.16 format, FSM encoding,
// and per-dimension codebook geometry for the 2400 bit/s encoder.
package lsp_cb_pkg;

  localparam int unsigned FRAC_BITS   = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_CB      = 10;
  localparam int unsigned CB_SIZE_DEF = 16;
  localparam int unsigned ADDR_W_DEF  = 4;

  // Address width of codebooks cb1..cb10 (36 bits of scalar LSP index in total).
  localparam int unsigned CB_ADDR_W [NUM_CB] = '{4, 4, 4, 4, 4, 4, 4, 3, 3, 2};

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } state_e;

  function automatic int unsigned cb_size(input int unsigned dim);
    return 32'd1 << CB_ADDR_W[dim];
  endfunction

endpackage

// File: rtl/lsp_abs_diff.sv
// Combinational |a - b| of two signed Q15.16 values, widened by one bit so the
// magnitude never wraps.
module lsp_abs_diff #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   mag_o
);

  logic [N:0] diff;

  assign diff  = {a_i[N-1], a_i} - {b_i[N-1], b_i};
  // A diff of -2^N negates to 2^N, which is still the right unsigned magnitude.
  assign mag_o = diff[N] ? (N+1)'(-diff) : diff;

endmodule

// File: rtl/lsp_cb_search.sv
// Sequential nearest-neighbour search over one scalar LSP codebook ROM; sweeps one
// entry per cycle and reports the lowest-index minimum-error entry.
module lsp_cb_search
  import lsp_cb_pkg::*;
#(
  parameter int unsigned N       = DATA_W,
  parameter int unsigned CB_SIZE = CB_SIZE_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      target_in,
  output logic [ADDR_W-1:0] cb_addr,
  input  logic [N-1:0]      cb_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] best_index,
  output logic [N:0]        best_error
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CB_SIZE - 1);

  state_e            state_q, state_d;
  logic              req_q;
  logic [N-1:0]      target_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] min_idx_q;
  logic [N:0]        min_err_q;
  logic [ADDR_W-1:0] best_idx_q;
  logic [N:0]        best_err_q;
  logic [N:0]        err;

  lsp_abs_diff #(
    .N(N)
  ) u_abs_diff (
    .a_i  (target_q),
    .b_i  (cb_data),
    .mag_o(err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // An accepted start is held in req_q for one cycle before the sweep begins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_q) state_d = StSearch;
      StSearch: if (addr_q == LastAddr) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      target_q   <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      min_idx_q  <= '0;
      min_err_q  <= '0;
      best_idx_q <= '0;
      best_err_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_q) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
          end else if (start) begin
            req_q    <= 1'b1;
            target_q <= target_in;
          end
        end
        StSearch: begin
          // Strict compare keeps the lowest index on ties.
          if (!valid_q || err < min_err_q) begin
            min_err_q <= err;
            min_idx_q <= addr_q;
            valid_q   <= 1'b1;
          end
          addr_q <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
        end
        StDone: begin
          best_idx_q <= min_idx_q;
          best_err_q <= min_err_q;
        end
        default: ;
      endcase
    end
  end

  assign cb_addr = addr_q;

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    best_index = best_idx_q;
    best_error = best_err_q;
    unique case (state_q)
      StSearch: busy = 1'b1;
      StDone: begin
        done       = 1'b1;
        best_index = min_idx_q;
        best_error = min_err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/lsp_cb_search.md
Name: lsp_cb_search

Overview:
- Sequential nearest-neighbour search over one scalar LSP codebook ROM for the CODEC2_ENCODE_2400 encoder.
- Sits between the LSP-to-frequency stage and the codebook ROM.
- Latches one target value, sweeps the ROM one entry per cycle, and returns the index with the smallest absolute error plus that error.
- Used once per LSP dimension by the cbselect top level; the codebook ROM is passed in through the ROM port.

Parameters:
- N, 32: data width; signed fixed point, 1 sign / 15 integer / 16 fraction bits (Q15.16).
- CB_SIZE, 16: number of codebook entries; must be a power of two.
- ADDR_W, 4: address width; log2(CB_SIZE).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- target_in  in  N  value to quantise (Q15.16); sampled on the accepted start.
- cb_addr  out  ADDR_W  codebook ROM address.
- cb_data  in  N  ROM output (Q15.16); combinational, valid in the same cycle as cb_addr.
- busy  out  1  high while in the SEARCH state.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- best_index  out  ADDR_W  index of the minimum-error entry.
- best_error  out  N+1  unsigned |target - cb[best_index]|, in Q16.16 magnitude.

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE. cb_addr, busy, done, best_index and best_error all go to 0. The latched target clears. Reset takes priority over everything, including mid-search; any partial search is discarded.
- FSM states are IDLE, SEARCH and DONE.
  - IDLE: on start=1, latch target_in, set cb_addr=0, clear the running minimum (valid flag low), go to SEARCH.
  - SEARCH: each cycle, compute err = |target - cb_data| at cb_addr.
    - Sign-extend both operands to N+1 bits before subtracting, then take the absolute value. No overflow and no saturation occur.
    - If the valid flag is low, or err < the running minimum (strictly less), load the minimum and its index. Ties therefore keep the lowest index.
    - Increment cb_addr. Leave SEARCH after evaluating address CB_SIZE-1.
  - DONE: assert done for exactly one cycle, drive best_index/best_error from the running minimum, return to IDLE.
- Latency: start sampled at edge 0; SEARCH occupies the cycles after edges 1..CB_SIZE; done is high in the cycle after edge CB_SIZE+1. For CB_SIZE=16, the search takes 18 cycles from start to the end of done.
- A new start is accepted the cycle after done, at the earliest.
- start during SEARCH or DONE is ignored; it is not queued.
- busy is high in SEARCH only. cb_addr wraps to 0 on leaving SEARCH and holds 0 in IDLE.
- best_index and best_error hold their values until the next done. They update only at done, never mid-search.
- target_in changes after the start is accepted have no effect.

Decomposition:
- Shared package/include (lsp_cb_pkg):
  - Q15.16 constants: FRAC_BITS=16, N=32.
  - FSM state encodings: IDLE=2'd0, SEARCH=2'd1, DONE=2'd2.
  - CB_SIZE/ADDR_W defaults for codebooks cb1..cb10.
- One natural sub-module: lsp_abs_diff. It is combinational and N+1 bits wide; it produces the sign-extended absolute difference.
- The FSM, running minimum and address counter stay in lsp_cb_search.
- The ROM is instantiated outside this block, by cbselect.

Test Plan:
- Bench drives cb_data from a model of codebook codes4 (950..2450 Hz, step 100, Q15.16).
- Target 1234.0 (0x04D20000) -> best_index=3, best_error=0x00100000 (16.0); done exactly 17 edges after the start edge; busy high for 16 cycles.
- Tie: target 1000.0 (0x03E80000) -> best_index=0 (lowest index of the 950/1050 tie), best_error=0x00320000. Target 1700.0 -> best_index=7.
- Extremes:
  - Target 2500.0 -> best_index=15, best_error=0x00320000.
  - Target -5.0 (0xFFFB0000) -> best_index=0, best_error=0x03BB0000 (955.0).
  - Target 0x7FFFFFFF -> best_index=15, with no wrap of the error.
- start pulsed mid-SEARCH with a different target -> ignored; results match the first target. Back-to-back starts (second start the cycle after done) give two correct results.
- rst asserted at SEARCH cycle 8 -> next cycle busy=0, done=0, cb_addr=0, best_index=0, best_error=0. A fresh search afterwards returns correct values.
